// File: rtl/bist_pkg.sv
// Shared BIST definitions: FSM state encoding, pattern geometry and the
// walking-ones pattern function used by both the write-side generator and
// the read-side checker so the two patterns cannot drift apart.
package bist_pkg;

    localparam int unsigned BIST_WIDTH = 10;
    localparam int unsigned BIST_DEPTH = 10;
    localparam int unsigned BIST_IDX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Walking-ones word for pattern index idx.
    function automatic logic [BIST_WIDTH-1:0] onehot(input logic [BIST_IDX_W-1:0] idx);
        onehot = BIST_WIDTH'(1) << idx;
    endfunction

endpackage

// File: rtl/bist_checker.sv
// Read-side response analyser for the FIFO BIST.
// Checks each valid FIFO read word against the walking-ones pattern,
// counts mismatches (saturating), captures the first failure and reports
// a pass/fail verdict once DEPTH*PASSES words have been consumed.
//
// Ports:
//   R_CLK     in   read-domain clock
//   R_RST     in   asynchronous active-high reset
//   START     in   run request (honoured in IDLE and DONE)
//   DOUT_VLD  in   FIFO read data valid
//   DOUT      in   FIFO read data
//   BUSY      out  run in progress
//   DONE      out  run finished, held until START or reset
//   PASS      out  DONE with zero mismatches
//   ERR_CNT   out  saturating mismatch count for this run
//   FAIL_IDX  out  expected index of the first mismatch
//   FAIL_DATA out  data word of the first mismatch
module bist_checker
    import bist_pkg::*;
#(
    parameter int unsigned WIDTH  = BIST_WIDTH,
    parameter int unsigned DEPTH  = BIST_DEPTH,
    parameter int unsigned PASSES = 2,
    parameter int unsigned ERR_W  = 5
) (
    input  logic             R_CLK,
    input  logic             R_RST,
    input  logic             START,
    input  logic             DOUT_VLD,
    input  logic [WIDTH-1:0] DOUT,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic [3:0]       FAIL_IDX,
    output logic [WIDTH-1:0] FAIL_DATA
);

    localparam int unsigned IDX_W = BIST_IDX_W;
    localparam int unsigned TOTAL = DEPTH * PASSES;
    localparam int unsigned CNT_W = $clog2(TOTAL + 1);

    state_t             state_q,     state_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;
    logic               pass_q,      pass_d;
    logic [ERR_W-1:0]   err_cnt_q,   err_cnt_d;
    logic [IDX_W-1:0]   fail_idx_q,  fail_idx_d;
    logic [WIDTH-1:0]   fail_data_q, fail_data_d;
    logic [IDX_W-1:0]   exp_idx_q,   exp_idx_d;
    logic [CNT_W-1:0]   word_cnt_q,  word_cnt_d;
    logic               first_q,     first_d;

    logic [WIDTH-1:0]   exp_c;
    logic               mismatch_c;

    assign exp_c      = WIDTH'(onehot(exp_idx_q));
    assign mismatch_c = (DOUT != exp_c);

    // State and datapath registers.
    always_ff @(posedge R_CLK or posedge R_RST) begin
        if (R_RST) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= '0;
            fail_idx_q  <= '0;
            fail_data_q <= '0;
            exp_idx_q   <= '0;
            word_cnt_q  <= '0;
            first_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_cnt_q   <= err_cnt_d;
            fail_idx_q  <= fail_idx_d;
            fail_data_q <= fail_data_d;
            exp_idx_q   <= exp_idx_d;
            word_cnt_q  <= word_cnt_d;
            first_q     <= first_d;
        end
    end

    // Next-state, checking and capture logic.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        err_cnt_d   = err_cnt_q;
        fail_idx_d  = fail_idx_q;
        fail_data_d = fail_data_q;
        exp_idx_d   = exp_idx_q;
        word_cnt_d  = word_cnt_q;
        first_d     = first_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                // Data arriving alongside START belongs to no run and is dropped.
                if (START) begin
                    state_d     = ST_CHECK;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    err_cnt_d   = '0;
                    fail_idx_d  = '0;
                    fail_data_d = '0;
                    exp_idx_d   = '0;
                    word_cnt_d  = '0;
                    first_d     = 1'b0;
                end
            end
            ST_CHECK: begin
                if (DOUT_VLD) begin
                    if (mismatch_c) begin
                        if (err_cnt_q != {ERR_W{1'b1}}) begin
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
                        if (!first_q) begin
                            fail_idx_d  = exp_idx_q;
                            fail_data_d = DOUT;
                            first_d     = 1'b1;
                        end
                    end
                    exp_idx_d = (exp_idx_q == IDX_W'(DEPTH - 1)) ? '0
                                                                : exp_idx_q + IDX_W'(1);
                    word_cnt_d = word_cnt_q + CNT_W'(1);
                    // Verdict uses the count including this final word.
                    if (word_cnt_q == CNT_W'(TOTAL - 1)) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_cnt_d == '0);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                pass_d  = 1'b0;
            end
        endcase
    end

    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign PASS      = pass_q;
    assign ERR_CNT   = err_cnt_q;
    assign FAIL_IDX  = fail_idx_q;
    assign FAIL_DATA = fail_data_q;

endmodule

// File: tb/tb_bist_checker.sv
// Testbench for bist_checker: a vector table covering clean, faulty and
// restarted runs, plus hand-written sequences for saturation, gapped
// traffic and asynchronous reset in the middle of a run.
module tb_bist_checker;

    logic       R_CLK = 1'b0;
    logic       R_RST;
    logic       START;
    logic       DOUT_VLD;
    logic [9:0] DOUT;

    logic       BUSY, DONE, PASS;
    logic [4:0] ERR_CNT;
    logic [3:0] FAIL_IDX;
    logic [9:0] FAIL_DATA;

    logic       BUSY2, DONE2, PASS2;
    logic [1:0] ERR_CNT2;
    logic [3:0] FAIL_IDX2;
    logic [9:0] FAIL_DATA2;

    int n_vec = 0;
    int n_mis = 0;

    always #5 R_CLK = ~R_CLK;

    bist_checker #(.WIDTH(10), .DEPTH(10), .PASSES(2), .ERR_W(5)) dut (
        .R_CLK(R_CLK), .R_RST(R_RST), .START(START), .DOUT_VLD(DOUT_VLD), .DOUT(DOUT),
        .BUSY(BUSY), .DONE(DONE), .PASS(PASS), .ERR_CNT(ERR_CNT),
        .FAIL_IDX(FAIL_IDX), .FAIL_DATA(FAIL_DATA)
    );

    bist_checker #(.WIDTH(10), .DEPTH(10), .PASSES(2), .ERR_W(2)) dut_sat (
        .R_CLK(R_CLK), .R_RST(R_RST), .START(START), .DOUT_VLD(DOUT_VLD), .DOUT(DOUT),
        .BUSY(BUSY2), .DONE(DONE2), .PASS(PASS2), .ERR_CNT(ERR_CNT2),
        .FAIL_IDX(FAIL_IDX2), .FAIL_DATA(FAIL_DATA2)
    );

    typedef struct {
        logic       start;
        logic       vld;
        logic [9:0] dout;
        logic       busy;
        logic       done;
        logic       pass;
        logic [4:0] err;
        logic [3:0] fidx;
        logic [9:0] fdata;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [9:0] oh(input int k);
        logic [9:0] v;
        v = 10'd1 << k;
        return v;
    endfunction

    function automatic void add(input logic s, input logic v, input logic [9:0] d,
                                input logic b, input logic dn, input logic p,
                                input logic [4:0] e, input logic [3:0] fi, input logic [9:0] fd);
        vec_t x;
        x.start = s; x.vld = v; x.dout = d;
        x.busy = b; x.done = dn; x.pass = p;
        x.err = e; x.fidx = fi; x.fdata = fd;
        vecs.push_back(x);
    endfunction

    task automatic step(input logic s, input logic v, input logic [9:0] d);
        START = s; DOUT_VLD = v; DOUT = d;
        @(posedge R_CLK);
        #1;
    endtask

    task automatic check(input string nm, input logic b, input logic dn, input logic p,
                         input logic [4:0] e, input logic [3:0] fi, input logic [9:0] fd);
        n_vec++;
        if (BUSY !== b) begin
            n_mis++; $display("FAIL %s BUSY got %0b want %0b", nm, BUSY, b);
        end
        if (DONE !== dn) begin
            n_mis++; $display("FAIL %s DONE got %0b want %0b", nm, DONE, dn);
        end
        if (PASS !== p) begin
            n_mis++; $display("FAIL %s PASS got %0b want %0b", nm, PASS, p);
        end
        if (ERR_CNT !== e) begin
            n_mis++; $display("FAIL %s ERR_CNT got %0d want %0d", nm, ERR_CNT, e);
        end
        if (FAIL_IDX !== fi) begin
            n_mis++; $display("FAIL %s FAIL_IDX got %0d want %0d", nm, FAIL_IDX, fi);
        end
        if (FAIL_DATA !== fd) begin
            n_mis++; $display("FAIL %s FAIL_DATA got %h want %h", nm, FAIL_DATA, fd);
        end
    endtask

    // Clean run of 20 words with optional random 0-3 cycle gaps; checks verdict.
    task automatic clean_run(input string nm, input bit gaps);
        step(1'b1, 1'b1, 10'h000);
        check({nm, "_start"}, 1'b1, 1'b0, 1'b0, 5'd0, 4'd0, 10'h000);
        for (int k = 0; k < 20; k++) begin
            if (gaps) begin
                int g;
                g = int'($urandom_range(0, 3));
                for (int j = 0; j < g; j++) step(1'b0, 1'b0, 10'h3FF);
            end
            step(1'b0, 1'b1, oh(k % 10));
            if (k == 18) check({nm, "_w19"}, 1'b1, 1'b0, 1'b0, 5'd0, 4'd0, 10'h000);
        end
        check({nm, "_end"}, 1'b0, 1'b1, 1'b1, 5'd0, 4'd0, 10'h000);
    endtask

    initial begin
        R_RST = 1'b1; START = 1'b0; DOUT_VLD = 1'b0; DOUT = '0;

        // Run 1 clean, DONE ignores data, restart, run 2 with one fault,
        // restart from a failed DONE, run 3 clean.
        add(1, 1, 10'h3FF, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++)
            add(0, 1, oh(k % 10), k != 19, k == 19, k == 19, 0, 0, 0);
        add(0, 1, 10'h000, 0, 1, 1, 0, 0, 0);
        add(1, 0, 10'h000, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            logic hit;
            hit = (k >= 12);
            add(0, 1, (k == 12) ? 10'h00C : oh(k % 10), k != 19, k == 19, 1'b0,
                hit ? 5'd1 : 5'd0, hit ? 4'd2 : 4'd0, hit ? 10'h00C : 10'h000);
        end
        add(0, 1, 10'h000, 0, 1, 0, 1, 2, 10'h00C);
        add(1, 0, 10'h000, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 20; k++)
            add(0, 1, oh(k % 10), k != 19, k == 19, k == 19, 0, 0, 0);

        repeat (2) @(posedge R_CLK);
        #1 R_RST = 1'b0;
        check("reset", 1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 10'h000);
        step(1'b0, 1'b1, 10'h000);
        check("idle_vld", 1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 10'h000);

        foreach (vecs[i]) begin
            step(vecs[i].start, vecs[i].vld, vecs[i].dout);
            check($sformatf("vec%0d", i), vecs[i].busy, vecs[i].done, vecs[i].pass,
                  vecs[i].err, vecs[i].fidx, vecs[i].fdata);
        end
        n_vec++;
        if (PASS2 !== 1'b1) begin
            n_mis++; $display("FAIL sat_inst_clean PASS got %0b want 1", PASS2);
        end

        // All-zero run: every word mismatches; narrow counter saturates at 3.
        step(1'b1, 1'b0, 10'h000);
        for (int k = 0; k < 20; k++) step(1'b0, 1'b1, 10'h000);
        check("zeros", 1'b0, 1'b1, 1'b0, 5'd20, 4'd0, 10'h000);
        n_vec++;
        if (ERR_CNT2 !== 2'd3 || FAIL_IDX2 !== 4'd0 || FAIL_DATA2 !== 10'h000 || PASS2 !== 1'b0) begin
            n_mis++;
            $display("FAIL saturate got err=%0d idx=%0d data=%h pass=%0b want err=3 idx=0 data=000 pass=0",
                     ERR_CNT2, FAIL_IDX2, FAIL_DATA2, PASS2);
        end

        // Gapped traffic, then data presented while DONE must be ignored.
        clean_run("gapped", 1'b1);
        step(1'b0, 1'b1, 10'h000);
        step(1'b0, 1'b1, 10'h000);
        check("done_vld", 1'b0, 1'b1, 1'b1, 5'd0, 4'd0, 10'h000);

        // Seven words with one fault, then asynchronous reset mid-run.
        step(1'b1, 1'b0, 10'h000);
        step(1'b0, 1'b1, 10'h000);
        for (int k = 1; k < 7; k++) step(1'b0, 1'b1, oh(k));
        check("pre_reset", 1'b1, 1'b0, 1'b0, 5'd1, 4'd0, 10'h000);
        step(1'b0, 1'b0, 10'h000);
        R_RST = 1'b1;
        #2;
        check("async_reset", 1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 10'h000);
        R_RST = 1'b0;
        step(1'b0, 1'b1, 10'h001);
        check("post_reset_idle", 1'b0, 1'b0, 1'b0, 5'd0, 4'd0, 10'h000);
        clean_run("after_reset", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/bist_checker.md
# bist_checker

Read-side response analyser for the FIFO BIST. It consumes words read out of the FIFO under test, checks each one against the expected walking-ones pattern (word at index i = 1 << i), counts mismatches and captures the first failure. At the end of the run it presents a pass/fail verdict to the BIST top level. It sits directly downstream of the FIFO read port, in the read clock domain.

## Interface
Parameters:
- WIDTH, 10 — data word width; equals the pattern length.
- DEPTH, 10 — words per pass; expected index wraps DEPTH-1 → 0.
- PASSES, 2 — full passes checked per run; total words = DEPTH*PASSES.
- ERR_W, 5 — error counter width.

Ports:
- R_CLK  in  1  read-domain clock; all logic on posedge.
- R_RST  in  1  reset, asynchronous, active-high; deassertion already synchronised to R_CLK at top level.
- START  in  1  run request; sampled on posedge.
- DOUT_VLD  in  1  FIFO read data valid this cycle.
- DOUT  in  WIDTH  FIFO read data.
- BUSY  out  1  run in progress.
- DONE  out  1  run finished; held until next START or reset.
- PASS  out  1  DONE && ERR_CNT==0.
- ERR_CNT  out  ERR_W  mismatching words this run; saturating.
- FAIL_IDX  out  4  expected index of first mismatch.
- FAIL_DATA  out  WIDTH  DOUT of first mismatch.

## Operation
- States: IDLE, CHECK, DONE.
- IDLE: DOUT_VLD ignored. START → CHECK; clears EXP_IDX, word count, ERR_CNT, FAIL_IDX, FAIL_DATA and the first-fail flag.
- CHECK: each DOUT_VLD compares DOUT against EXP = 1 << EXP_IDX (WIDTH bits, exactly one bit set). Any difference, including zero or multi-hot data, is a mismatch.
  - EXP_IDX increments on every valid word, mismatched or not; DEPTH-1 wraps to 0.
  - Word count increments on every valid word.
  - After word DEPTH*PASSES-1 is consumed: → DONE.
  - START ignored in CHECK.
- Mismatch handling:
  - ERR_CNT += 1, saturating at 2^ERR_W-1.
  - If the first-fail flag is clear: latch FAIL_IDX = EXP_IDX and FAIL_DATA = DOUT, then set the flag. Later mismatches do not overwrite.
- DONE: DOUT_VLD ignored. Results held. START → CHECK with the same clearing as from IDLE.
- Reset, from any state including mid-run: state = IDLE; BUSY, DONE, PASS = 0; ERR_CNT, FAIL_IDX, FAIL_DATA, EXP_IDX and word count = 0.

## Timing
- All outputs are registered.
- START at posedge n: BUSY=1 from n+1. A DOUT_VLD at posedge n is not checked; the first checked word is at n+1 or later.
- Valid word at posedge m: ERR_CNT and FAIL_* update visible from m+1.
- Final word at posedge m:
  - From m+1: DONE=1, BUSY=0, PASS valid, ERR_CNT includes the final word.
  - DONE and PASS never assert before ERR_CNT is final.
- START in DONE at posedge n: DONE and PASS drop and BUSY rises at n+1; counters read 0 at n+1.
- Back-to-back DOUT_VLD every cycle is supported; gaps of any length are tolerated.
- Minimum run length: DEPTH*PASSES cycles from the first checked word.

## Structure
- Package bist_pkg:
  - state enum (IDLE, CHECK, DONE);
  - BIST_WIDTH = 10, BIST_DEPTH = 10 constants;
  - function onehot(idx) returning WIDTH-bit 1 << idx.
  - Shared with the write-side pattern generator so expected and written patterns stay identical.
- No sub-module. FSM, index counter, word counter, error counter and capture registers live in one module.

## Test plan
- Clean run: START, then 20 words (1,2,4,…,512,1,…,512) with DOUT_VLD every cycle → DONE and PASS=1 one cycle after word 20, ERR_CNT=0, BUSY low.
- Single fault: word 13 (EXP_IDX=2, expected 0x004) driven as 0x00C → ERR_CNT=1, FAIL_IDX=2, FAIL_DATA=0x00C, PASS=0.
- Multiple faults and saturation: ERR_W=2, 20 words all 0x000 → ERR_CNT=3, FAIL_IDX=0, FAIL_DATA=0x000.
- Gapped valid plus ignored inputs:
  - DOUT_VLD asserted with START, and again in DONE → neither counted.
  - Clean words with random 0–3 cycle gaps → PASS=1 after exactly 20 words.
- Reset mid-run: R_RST pulsed after word 7 of a run with one prior error → all outputs 0, state IDLE. A following clean run → PASS=1.
- Restart from DONE: failed run, then START → ERR_CNT=0 and DONE=0 next cycle; clean second run → PASS=1.
